// File: rtl/id_pkg.sv
// -----------------------------------------------------------------------------
// id_pkg
// Shared definitions for the decode stage: supported opcodes, ALUOp
// encodings, immediate format selector and the decoded control bundle.
// -----------------------------------------------------------------------------
package id_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_IALU   = 2'b11;

  typedef enum logic [1:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B
  } imm_type_e;

  typedef struct packed {
    logic       alusrc;
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Formats whose rs2 field is a real source operand. I-type and LOAD carry
  // immediate bits there, so a match on those must not stall.
  function automatic logic reads_rs2(input logic [6:0] opcode);
    return (opcode == OPC_R) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/id_ctrl_decode.sv
// -----------------------------------------------------------------------------
// id_ctrl_decode
// Purely combinational decode of one instruction word: control bundle,
// illegal-opcode flag, register fields and the sign-extended immediate.
//
// Ports
//   instr        in   32    instruction word
//   rs1, rs2, rd out  5     register fields
//   alu_control  out  10    {funct7, funct3}
//   alu_op       out  2     ALUOp class
//   alusrc .. regwrite out 1 datapath controls
//   illegal      out  1     opcode outside the supported set
//   imm          out  XLEN  sign-extended immediate (0 for R / illegal)
// -----------------------------------------------------------------------------
module id_ctrl_decode
  import id_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [9:0]      alu_control,
  output logic [1:0]      alu_op,
  output logic            alusrc,
  output logic            branch,
  output logic            memread,
  output logic            memwrite,
  output logic            memtoreg,
  output logic            regwrite,
  output logic            illegal,
  output logic [XLEN-1:0] imm
);

  ctrl_t     ctrl;
  imm_type_e imm_type;

  always_comb begin
    ctrl     = CTRL_NONE;
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    case (instr[6:0])
      OPC_R: begin
        ctrl.regwrite = 1'b1;
        ctrl.alu_op   = ALUOP_RTYPE;
      end
      OPC_I_ALU: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.alu_op   = ALUOP_IALU;
        imm_type      = IMM_I;
      end
      OPC_LOAD: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.alu_op   = ALUOP_LDST;
        imm_type      = IMM_I;
      end
      OPC_STORE: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.alu_op   = ALUOP_LDST;
        imm_type      = IMM_S;
      end
      OPC_BRANCH: begin
        ctrl.branch   = 1'b1;
        ctrl.alu_op   = ALUOP_BRANCH;
        imm_type      = IMM_B;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
      default: imm = '0;
    endcase
  end

  assign rs1         = instr[19:15];
  assign rs2         = instr[24:20];
  assign rd          = instr[11:7];
  assign alu_control = {instr[31:25], instr[14:12]};
  assign alu_op      = ctrl.alu_op;
  assign alusrc      = ctrl.alusrc;
  assign branch      = ctrl.branch;
  assign memread     = ctrl.memread;
  assign memwrite    = ctrl.memwrite;
  assign memtoreg    = ctrl.memtoreg;
  assign regwrite    = ctrl.regwrite;

endmodule

// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe
// Decode stage with built-in ID/EX register. Takes an instruction plus its
// register-file read data under valid/ready, registers the decoded payload
// and presents it to EX one cycle later. Handles flush, back-pressure and
// (optionally) load-use bubble insertion.
//
// Build option
//   ID_HAZARD_DETECT_EN  defined: load-use hazard detection, one-cycle bubble
//                        insertion and a saturating bubble counter.
//                        undefined: hazard tied low, stall_count tied 0.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        upstream handshake
//   in_pc, in_instr          fetched instruction
//   rf_rs1, rf_rs2           register-file read addresses (combinational)
//   rs1_data, rs2_data       register-file read data, same cycle
//   flush                    drop held and incoming instruction
//   out_valid/out_ready      EX handshake
//   out_*                    registered decoded payload
//   stall_count              number of bubbles inserted (saturating)
// -----------------------------------------------------------------------------
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [31:0]            in_instr,
  output logic [4:0]             rf_rs1,
  output logic [4:0]             rf_rs2,
  input  logic [XLEN-1:0]        rs1_data,
  input  logic [XLEN-1:0]        rs2_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_rs1_data,
  output logic [XLEN-1:0]        out_rs2_data,
  output logic [XLEN-1:0]        out_imm,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [9:0]             out_alu_control,
  output logic [1:0]             out_alu_op,
  output logic                   out_alusrc,
  output logic                   out_branch,
  output logic                   out_memread,
  output logic                   out_memwrite,
  output logic                   out_memtoreg,
  output logic                   out_regwrite,
  output logic [31:0]            out_instr,
  output logic                   out_illegal,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic [4:0]      d_rd;
  logic [9:0]      d_alu_control;
  logic [1:0]      d_alu_op;
  logic            d_alusrc;
  logic            d_branch;
  logic            d_memread;
  logic            d_memwrite;
  logic            d_memtoreg;
  logic            d_regwrite;
  logic            d_illegal;
  logic [XLEN-1:0] d_imm;

  logic advance;
  logic hazard;
  logic load;

  id_ctrl_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr       (in_instr),
    .rs1         (rf_rs1),
    .rs2         (rf_rs2),
    .rd          (d_rd),
    .alu_control (d_alu_control),
    .alu_op      (d_alu_op),
    .alusrc      (d_alusrc),
    .branch      (d_branch),
    .memread     (d_memread),
    .memwrite    (d_memwrite),
    .memtoreg    (d_memtoreg),
    .regwrite    (d_regwrite),
    .illegal     (d_illegal),
    .imm         (d_imm)
  );

  // The register can take a new word when it is empty or EX drains it now.
  assign advance = !out_valid || out_ready;

`ifdef ID_HAZARD_DETECT_EN
  // A load sitting in ID/EX whose destination feeds the instruction now in
  // decode: its data only exists after MEM, so hold decode for one cycle.
  assign hazard = out_valid && out_memread && (out_rd != 5'd0) &&
                  ((out_rd == rf_rs1) ||
                   ((out_rd == rf_rs2) && reads_rs2(in_instr[6:0])));
`else
  assign hazard = 1'b0;
`endif

  // Held low during reset so upstream sees ready only after release.
  assign in_ready = !rst && advance && !hazard && !flush;
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_pc          <= '0;
      out_rs1_data    <= '0;
      out_rs2_data    <= '0;
      out_imm         <= '0;
      out_rd          <= '0;
      out_rs1         <= '0;
      out_rs2         <= '0;
      out_alu_control <= '0;
      out_alu_op      <= '0;
      out_alusrc      <= 1'b0;
      out_branch      <= 1'b0;
      out_memread     <= 1'b0;
      out_memwrite    <= 1'b0;
      out_memtoreg    <= 1'b0;
      out_regwrite    <= 1'b0;
      out_instr       <= '0;
      out_illegal     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid       <= 1'b1;
      out_pc          <= in_pc;
      out_rs1_data    <= rs1_data;
      out_rs2_data    <= rs2_data;
      out_imm         <= d_imm;
      out_rd          <= d_rd;
      out_rs1         <= rf_rs1;
      out_rs2         <= rf_rs2;
      out_alu_control <= d_alu_control;
      out_alu_op      <= d_alu_op;
      out_alusrc      <= d_alusrc;
      out_branch      <= d_branch;
      out_memread     <= d_memread;
      out_memwrite    <= d_memwrite;
      out_memtoreg    <= d_memtoreg;
      out_regwrite    <= d_regwrite;
      out_instr       <= in_instr;
      out_illegal     <= d_illegal;
    end else if (advance) begin
      // Bubble or plain drain: either way the slot empties, payload is kept.
      out_valid <= 1'b0;
    end
  end

`ifdef ID_HAZARD_DETECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (!flush && advance && hazard && (stall_count != '1)) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end
`else
  assign stall_count = '0;
`endif

endmodule
